// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath strobes and the ALU operation code, and raises traps.
module mips_mc_controller #(
  parameter int selBits = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               ovf,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic [selBits-1:0] alu_sel,
  output logic               exc,
  output logic [1:0]         exc_cause
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_EXC
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL = 4'd2,
                         ALU_SRL  = 4'd3,  ALU_SLLV = 4'd4,  ALU_SRLV = 4'd5,
                         ALU_SRA  = 4'd6,  ALU_AND  = 4'd7,  ALU_OR  = 4'd8,
                         ALU_XOR  = 4'd9,  ALU_SRAV = 4'd11;

  state_t     state_reg, state_next;
  logic [1:0] exc_cause_reg, cause_next;
  logic [3:0] r_alu, i_alu, alu_code;
  logic       funct_ok, trap_r, trap_i;
  logic       mem_write_s, ir_write_s, reg_write_s, pc_en_s, exc_s;

  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_ADD;
    case (funct)
      6'h20, 6'h21: r_alu = ALU_ADD;
      6'h22, 6'h23: r_alu = ALU_SUB;
      6'h24:        r_alu = ALU_AND;
      6'h25:        r_alu = ALU_OR;
      6'h26:        r_alu = ALU_XOR;
      6'h00:        r_alu = ALU_SLL;
      6'h02:        r_alu = ALU_SRL;
      6'h03:        r_alu = ALU_SRA;
      6'h04:        r_alu = ALU_SLLV;
      6'h06:        r_alu = ALU_SRLV;
      6'h07:        r_alu = ALU_SRAV;
      default:      funct_ok = 1'b0;
    endcase
    case (opcode)
      6'h0C:   i_alu = ALU_AND;
      6'h0D:   i_alu = ALU_OR;
      6'h0E:   i_alu = ALU_XOR;
      default: i_alu = ALU_ADD;
    endcase
    // Only the signed forms trap; addu/subu ignore the overflow flag.
    trap_r = ovf && (funct == 6'h20 || funct == 6'h22);
    trap_i = ovf && (opcode == 6'h08);
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h23, 6'h2B:             state_next = S_MEMADR;
          6'h00:                    state_next = funct_ok ? S_EXEC : S_EXC;
          6'h04, 6'h05:             state_next = S_BRANCH;
          6'h08, 6'h0C, 6'h0D, 6'h0E: state_next = S_IEXEC;
          6'h02:                    state_next = S_JUMP;
          default:                  state_next = S_EXC;
        endcase
      end
      S_MEMADR: state_next = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = trap_r ? S_EXC : S_RWB;
      S_IEXEC:  state_next = trap_i ? S_EXC : S_IWB;
      default:  state_next = S_FETCH;
    endcase
    // Exceptions entered from DECODE are illegal opcodes/functs; the rest are overflow.
    cause_next = (state_reg == S_DECODE) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_FETCH;
      exc_cause_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (state_next == S_EXC)
        exc_cause_reg <= cause_next;
    end
  end

  always_comb begin
    iord        = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    ext_op      = 1'b0;
    pc_src      = 2'b00;
    pc_en_s     = 1'b0;
    exc_s       = 1'b0;
    alu_code    = ALU_ADD;
    case (state_reg)
      S_FETCH:  begin ir_write_s = 1'b1; alu_src_b = 2'b01; pc_en_s = 1'b1; end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB:  begin reg_write_s = 1'b1; mem_to_reg = 1'b1; end
      S_MEMWR:  begin iord = 1'b1; mem_write_s = 1'b1; end
      S_EXEC:   begin alu_src_a = 1'b1; alu_code = r_alu; end
      S_RWB:    begin reg_write_s = 1'b1; reg_dst = 1'b1; end
      S_IEXEC:  begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = (opcode != 6'h08);
        alu_code  = i_alu;
      end
      S_IWB:    reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = 2'b01;
        pc_en_s   = (opcode == 6'h05) ? ~zero : zero;
      end
      S_JUMP:   begin pc_src = 2'b10; pc_en_s = 1'b1; end
      S_EXC:    begin pc_src = 2'b11; pc_en_s = 1'b1; exc_s = 1'b1; end
      default:  ;
    endcase
  end

  assign mem_write = mem_write_s & ~rst;
  assign ir_write  = ir_write_s  & ~rst;
  assign reg_write = reg_write_s & ~rst;
  assign pc_en     = pc_en_s     & ~rst;
  assign exc       = exc_s       & ~rst;
  assign alu_sel   = selBits'(alu_code);
  assign exc_cause = exc_cause_reg;

endmodule
